// File: rtl/lc3b_types.sv
// Shared cache types: PLRU vector, way encoding and the PLRU store FSM state.
package lc3b_types;

    localparam int unsigned PLRU_W = 3;
    localparam int unsigned WAY_W  = 2;

    typedef logic [PLRU_W-1:0] lc3b_plru;
    typedef logic [WAY_W-1:0]  lc3b_way;

    localparam lc3b_plru PLRU_RESET = 3'b000;

    localparam lc3b_way WAY_A = 2'd0;
    localparam lc3b_way WAY_B = 2'd1;
    localparam lc3b_way WAY_C = 2'd2;
    localparam lc3b_way WAY_D = 2'd3;

    typedef enum logic {
        PLRU_IDLE  = 1'b0,
        PLRU_SWEEP = 1'b1
    } plru_state_e;

endpackage

// File: rtl/plru_update.sv
// Tree-PLRU next-state function: re-point the tree away from the accessed way.
module plru_update
    import lc3b_types::*;
(
    input  lc3b_plru cur,
    input  lc3b_way  way,
    output lc3b_plru next_lru
);

    always_comb begin
        next_lru = cur;
        unique case (way)
            WAY_A: begin
                next_lru[0] = 1'b0;
                next_lru[1] = 1'b0;
            end
            WAY_B: begin
                next_lru[0] = 1'b0;
                next_lru[1] = 1'b1;
            end
            WAY_C: begin
                next_lru[0] = 1'b1;
                next_lru[2] = 1'b0;
            end
            WAY_D: begin
                next_lru[0] = 1'b1;
                next_lru[2] = 1'b1;
            end
            default: next_lru = cur;
        endcase
    end

endmodule

// File: rtl/plru_array.sv
// Per-set pseudo-LRU store for the 4-way L2 with a sequential clear sweep.
// Define PLRU_BYPASS_EN to forward a same-cycle update to rd_lru.
module plru_array
    import lc3b_types::*;
#(
    parameter int unsigned num_sets = 8,
    parameter int unsigned index_w  = $clog2(num_sets)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [index_w-1:0] rd_index,
    output lc3b_plru           rd_lru,
    input  logic               upd_valid,
    input  logic [index_w-1:0] upd_index,
    input  lc3b_way            upd_way,
    input  logic               clear_req,
    output logic               busy
);

    localparam logic [index_w-1:0] LAST_IDX = index_w'(num_sets - 1);

    lc3b_plru           mem [num_sets];
    plru_state_e        state;
    logic [index_w-1:0] sweep_idx;
    lc3b_plru           wr_next;

    plru_update u_wr_update (
        .cur      (mem[upd_index]),
        .way      (upd_way),
        .next_lru (wr_next)
    );

    // Array and sweep FSM share one register process; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(num_sets); i++) begin
                mem[i] <= PLRU_RESET;
            end
            state     <= PLRU_IDLE;
            sweep_idx <= '0;
        end else begin
            unique case (state)
                PLRU_IDLE: begin
                    if (clear_req) begin
                        state     <= PLRU_SWEEP;
                        sweep_idx <= '0;
                    end else if (upd_valid) begin
                        mem[upd_index] <= wr_next;
                    end
                end
                PLRU_SWEEP: begin
                    mem[sweep_idx] <= PLRU_RESET;
                    sweep_idx      <= sweep_idx + index_w'(1);
                    if (sweep_idx == LAST_IDX) begin
                        state <= PLRU_IDLE;
                    end
                end
                default: state <= PLRU_IDLE;
            endcase
        end
    end

    assign busy = (state == PLRU_SWEEP);

`ifdef PLRU_BYPASS_EN
    lc3b_plru byp_next;
    logic     byp_hit;

    plru_update u_byp_update (
        .cur      (mem[rd_index]),
        .way      (upd_way),
        .next_lru (byp_next)
    );

    // An update that clear_req overrides is never written, so it is not forwarded.
    assign byp_hit = (state == PLRU_IDLE) && upd_valid && !clear_req
                   && (upd_index == rd_index);

    always_comb begin
        rd_lru = mem[rd_index];
        if (byp_hit) begin
            rd_lru = byp_next;
        end
        if (state == PLRU_SWEEP) begin
            rd_lru = PLRU_RESET;
        end
    end
`else
    always_comb begin
        rd_lru = mem[rd_index];
        if (state == PLRU_SWEEP) begin
            rd_lru = PLRU_RESET;
        end
    end
`endif

endmodule
